// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared defaults, architectural register indices and the
//               pending-write entry type for the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int c_data_w = 16;
    localparam int c_reg_aw = 4;
    localparam int c_depth  = 4;

    localparam logic [c_reg_aw-1:0] c_reg_pc = 4'd15;
    localparam logic [c_reg_aw-1:0] c_reg_lr = 4'd14;

    typedef struct packed {
        logic [c_reg_aw-1:0] reg_idx;
        logic [c_data_w-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo2
// Description : Circular FIFO accepting up to two entries and releasing one
//               per cycle; entries are exposed oldest-first for lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo2
    import wb_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int REG_AW = c_reg_aw,
    parameter int DEPTH  = c_depth
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_enq1,
    input  logic [REG_AW-1:0]                i_reg1,
    input  logic [DATA_W-1:0]                i_data1,
    input  logic                             i_enq2,
    input  logic [REG_AW-1:0]                i_reg2,
    input  logic [DATA_W-1:0]                i_data2,
    input  logic                             i_deq,
    output logic [$clog2(DEPTH):0]           o_count,
    output logic [DEPTH-1:0]                 o_age_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]     o_age_reg,
    output logic [DEPTH-1:0][DATA_W-1:0]     o_age_data
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [c_ptr_w-1:0]              r_wr_ptr;
    logic [c_ptr_w-1:0]              r_rd_ptr;
    logic [c_cnt_w-1:0]              r_count;
    logic [DEPTH-1:0][REG_AW-1:0]    r_mem_reg;
    logic [DEPTH-1:0][DATA_W-1:0]    r_mem_data;

    logic                            w_deq;
    logic [c_cnt_w-1:0]              w_enq_cnt;
    logic [c_ptr_w-1:0]              w_wr_ptr2;

    assign w_deq     = i_deq && (r_count != '0);
    assign w_enq_cnt = c_cnt_w'(i_enq1) + c_cnt_w'(i_enq2);
    // A lone second request takes the first free slot
    assign w_wr_ptr2 = i_enq1 ? (r_wr_ptr + c_ptr_w'(1)) : r_wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_enq_cnt[c_ptr_w-1:0];
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + w_enq_cnt - c_cnt_w'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (i_enq1) begin
                r_mem_reg[r_wr_ptr]  <= i_reg1;
                r_mem_data[r_wr_ptr] <= i_data1;
            end
            if (i_enq2) begin
                r_mem_reg[w_wr_ptr2]  <= i_reg2;
                r_mem_data[w_wr_ptr2] <= i_data2;
            end
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_age
            logic [c_ptr_w-1:0] w_idx;
            assign w_idx          = r_rd_ptr + c_ptr_w'(i);
            assign o_age_reg[i]   = r_mem_reg[w_idx];
            assign o_age_data[i]  = r_mem_data[w_idx];
            assign o_age_valid[i] = r_count > c_cnt_w'(i);
        end
    endgenerate

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Serialises up to two register writes per beat onto a single
//               register-file write port, with pending-write forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int REG_AW = c_reg_aw,
    parameter int DEPTH  = c_depth
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_wr1,
    input  logic [REG_AW-1:0]        in_reg1,
    input  logic [DATA_W-1:0]        in_data1,
    input  logic                     in_wr2,
    input  logic [REG_AW-1:0]        in_reg2,
    input  logic [DATA_W-1:0]        in_data2,
    output logic                     rf_we,
    output logic [REG_AW-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic [REG_AW-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic                            w_accept;
    logic                            w_enq1;
    logic                            w_enq2;
    logic [c_cnt_w-1:0]              w_count;
    logic [DEPTH-1:0]                w_age_valid;
    logic [DEPTH-1:0][REG_AW-1:0]    w_age_reg;
    logic [DEPTH-1:0][DATA_W-1:0]    w_age_data;
    logic                            w_fwd_hit;
    logic [DATA_W-1:0]               w_fwd_data;

    // Two free slots are always reserved so a beat never needs partial acceptance
    assign in_ready = w_count <= c_cnt_w'(DEPTH - 2);
    assign w_accept = in_valid && in_ready;
    assign w_enq1   = w_accept && in_wr1;
    assign w_enq2   = w_accept && in_wr2 && !(in_wr1 && (in_reg1 == in_reg2));

    wb_fifo2 #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_enq1      (w_enq1),
        .i_reg1      (in_reg1),
        .i_data1     (in_data1),
        .i_enq2      (w_enq2),
        .i_reg2      (in_reg2),
        .i_data2     (in_data2),
        .i_deq       (rf_we),
        .o_count     (w_count),
        .o_age_valid (w_age_valid),
        .o_age_reg   (w_age_reg),
        .o_age_data  (w_age_data)
    );

    assign rf_we     = w_count != '0;
    assign rf_waddr  = rf_we ? w_age_reg[0]  : '0;
    assign rf_wdata  = rf_we ? w_age_data[0] : '0;
    assign occupancy = w_count;

    // Entries are scanned oldest-first, so the last match is the youngest
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_age_valid[i] && (w_age_reg[i] == fwd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = w_age_data[i];
            end
        end
    end

    assign fwd_hit  = w_fwd_hit;
    assign fwd_data = w_fwd_data;

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DATA_W, default 16: register data width in bits.
REQ-002 Parameter REG_AW, default 4: register address width in bits (16 architectural registers).
REQ-003 Parameter DEPTH, default 4: pending-write queue entries; power of two, at least 2.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: reset, synchronous, active-high.
REQ-006 Port in_valid, input, 1: a write-back beat is offered this cycle.
REQ-007 Port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-008 Ports in_wr1 / in_wr2, input, 1 each: write request 1 and write request 2 are valid.
REQ-009 Ports in_reg1 / in_reg2, input, REG_AW each: destination register for request 1 and request 2.
REQ-010 Ports in_data1 / in_data2, input, DATA_W each: write data for request 1 and request 2.
REQ-011 Ports rf_we (1), rf_waddr (REG_AW) and rf_wdata (DATA_W), output: the single register-file write port.
REQ-012 Ports fwd_addr (input, REG_AW), fwd_hit (output, 1) and fwd_data (output, DATA_W): pending-write lookup.
REQ-013 Port occupancy, output, clog2(DEPTH)+1: number of valid queue entries.

Function
REQ-014 The block SHALL serialise up to two register writes per accepted beat onto one register-file port through a circular FIFO of DEPTH {reg, data} entries.
REQ-015 in_ready SHALL be 1 iff the free entries (DEPTH - occupancy) number at least 2; it is independent of in_wr1, in_wr2 and in_valid.
REQ-016 On an accepted beat, request 1 SHALL be enqueued before request 2; a request with its wrN signal low is not enqueued.
REQ-017 If in_wr1 && in_wr2 && in_reg1 == in_reg2, only request 1 SHALL be enqueued (one entry).
REQ-018 A beat accepted with in_wr1 == in_wr2 == 0 SHALL be consumed with no state change.
REQ-019 rf_we SHALL equal (occupancy != 0); rf_waddr and rf_wdata SHALL show the head entry, or zero when the queue is empty.
REQ-020 The head entry SHALL be dequeued at every clock edge where rf_we == 1; the drain rate is one entry per cycle.
REQ-021 An entry accepted at edge N SHALL first appear at the head no earlier than cycle N+1; there is no combinational input-to-rf path.
REQ-022 Enqueue and dequeue in the same cycle SHALL both take effect: occupancy_next = occupancy + enq_count - deq.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH.
REQ-024 fwd_hit SHALL be 1 iff any valid queue entry has reg == fwd_addr, evaluated combinationally.
REQ-025 fwd_data SHALL be the data of the youngest matching entry, or zero when fwd_hit == 0.
REQ-026 Entries being enqueued in the current cycle SHALL NOT be visible to the forwarding lookup.
REQ-027 The block SHALL hold no architectural state beyond the queue and does not interpret instruction encodings.

Reset
REQ-028 While reset is high at a clock edge: pointers := 0, occupancy := 0, and all entry valid state is cleared.
REQ-029 Queued writes pending at reset SHALL be discarded, including during a mid-drain reset.
REQ-030 In the cycle after reset: rf_we = 0, rf_waddr = 0, rf_wdata = 0, fwd_hit = 0, fwd_data = 0, in_ready = 1.
REQ-031 Beats offered while reset is high SHALL be ignored.

Structure
REQ-032 Package wb_pkg SHALL hold the default DATA_W, REG_AW and DEPTH values, the PC/LR register index constants (15, 14) and the wb_entry_t {reg, data} typedef.
REQ-033 The storage SHALL be a sub-module wb_fifo2: a dual-enqueue, single-dequeue FIFO exposing its entries for the forwarding search.
REQ-034 The forwarding priority search SHALL live in writeback_arbiter.

Verification
REQ-035 Reset, then one beat with wr1 = {r3, 0x1234} and wr2 = 0 -> next cycle rf_we = 1, r3 = 0x1234; following cycle rf_we = 0, occupancy = 0.
REQ-036 Beat with wr1 = {r15, 0x0040} and wr2 = {r14, 0x003C} -> r15 is written in cycle N+1 and r14 in cycle N+2, in that order.
REQ-037 Beat with wr1 = {r2, 0xAAAA} and wr2 = {r2, 0x5555} -> a single write of r2 = 0xAAAA; occupancy peaks at 1.
REQ-038 DEPTH = 4, with back-to-back dual-write beats every cycle -> in_ready drops once occupancy exceeds 2; no entry is lost or reordered; pointers wrap correctly over 20 beats.
REQ-039 Queue holds r5 = 0x0001 (older) and r5 = 0x0002 (younger), fwd_addr = 5 -> fwd_hit = 1, fwd_data = 0x0002; fwd_addr = 6 -> fwd_hit = 0, fwd_data = 0.
REQ-040 Reset asserted with 3 entries pending -> next cycle rf_we = 0, occupancy = 0; no pending entry is ever written afterwards.
